text_console: RTL and testbench
===============================

# text_console

Character-stream writer for the 64x16 text screen memory. Accepts bytes over a valid/ready handshake, interprets a small set of control codes, and writes glyph codes into the write port of the dual-port screen RAM whose other port is scanned by the video generator. Maintains the cursor and performs clear-screen and upward scroll by read-modify-write through the same RAM port. Sits between the CPU-side/UART byte source and the screen RAM.

## Interface
Parameters:
- COLS, 64, characters per row; power of two.
- ROWS, 16, rows per screen; power of two.
- BLANK, 8'h20, fill code used for clear, scroll and backspace.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  byte to display or interpret.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- vram_addr  out  10  screen RAM address, {row[3:0], col[5:0]}.
- vram_dout  out  8  write data to screen RAM.
- vram_we  out  1  write strobe, one location per cycle.
- vram_din  in  8  read data from screen RAM; valid one cycle after vram_addr is presented with vram_we=0.
- cursor_row  out  4  current cursor row.
- cursor_col  out  6  current cursor column.
- busy  out  1  a multi-cycle clear or scroll is in progress.

## Operation
- States: CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, FILL.
- Reset asserted, immediately: state=CLEAR, cursor=(0,0), in_ready=0, vram_we=0, vram_addr=0, vram_dout=0, busy=1.
- CLEAR writes BLANK to addresses 0..1023, one per cycle, then homes the cursor and enters IDLE.
- IDLE: in_ready=1, busy=0. A byte is accepted on in_valid && in_ready. in_ready is 0 in every other state.
- Decoding of an accepted byte:
  - 0x20..0xFF: PUT writes the byte at {row,col}, then col+1. At col 63 the write wraps to col 0 and performs a newline.
  - 0x0D: newline. col=0, row+1. On row 15, scroll.
  - 0x08: backspace. If col>0, col-1. Else if row>0, move to (row-1, 63). Else no move. PUT writes BLANK at the new position, including at (0,0).
  - 0x1C: home to (0,0); no RAM access.
  - 0x1F: CLEAR, then home.
  - All other 0x00..0x1F codes are consumed and ignored.
- Scroll (row-15 newline): for i=0..959, SCROLL_RD presents addr i+64; SCROLL_WR writes vram_din to addr i. FILL then writes BLANK to 960..1023. The cursor ends at (15,0).
- Address arithmetic is 10-bit unsigned. The index counter is 10 bits and terminates by compare (959, 1023), not by overflow.

## Timing
- Printable or backspace: accept at cycle N; vram_we=1 at N+1; in_ready=1 again at N+2. Maximum throughput is one byte per 2 cycles.
- Ignored code or home: accept at N, in_ready=1 at N+2, no vram_we.
- Cursor outputs update on the same edge that returns the state to IDLE, or enters SCROLL_RD/CLEAR. The cursor is never mid-value during busy.
- CLEAR: 1024 write cycles; busy=1 throughout; in_ready=1 on the following cycle.
- Scroll: 1920 copy cycles plus 64 fill cycles (1984 total) with busy=1.
- vram_we is never asserted in SCROLL_RD. Write data in SCROLL_WR is taken directly from vram_din.
- Simultaneous in_valid during busy: the byte is held by the source (ready low); nothing is lost or duplicated.
- Reset asserted mid-scroll or mid-clear: abort immediately; CLEAR restarts from address 0 after release.

## Configuration
- CONSOLE_SCROLL_EN defined: a newline on row 15 scrolls as described.
- CONSOLE_SCROLL_EN undefined:
  - A newline on row 15 wraps the cursor to (0,0).
  - FILL then blanks row 0 only (addresses 0..63, 64 cycles, busy=1).
  - SCROLL_RD and SCROLL_WR are not built, and vram_din is unused.

## Test plan
- Reset release -> 1024 consecutive writes of 0x20 to addresses 0..1023; in_ready=1 on the next cycle; cursor (0,0).
- Send 0x41 -> exactly one write, addr 0, data 0x41, one cycle after accept; cursor (0,1); in_ready high 2 cycles after accept.
- Send 64 printable bytes from (0,0) -> addresses 0..63 written in order; cursor (1,0). Then send 0x08 -> BLANK written at addr 63; cursor (0,63).
- Fill row r with value 0x40+r for every r via a RAM model, place cursor at (15,5), send 0x0D:
  - With the macro: RAM row r holds 0x41+r for r=0..14 and row 15 holds 0x20; busy high 1984 cycles; cursor (15,0).
  - Without the macro: row 0 holds 0x20, rows 1..15 unchanged; cursor (0,0).
- Hold in_valid high with 0x1F then 0x42 -> the clear completes before the second accept; 0x42 lands at addr 0.
- Assert reset 100 cycles into a scroll -> vram_we=0, in_ready=0, busy=1 immediately; after release, a full CLEAR from addr 0.

Source files
------------

// File: rtl/text_console_if.sv
// text_console_if: byte-stream handshake plus screen RAM write/read port bundle
interface text_console_if #(
  parameter int AW = 10
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_dout;
  logic          vram_we;
  logic [7:0]    vram_din;
  modport master (output in_data, in_valid, vram_din, input in_ready, vram_addr, vram_dout, vram_we);
  modport slave (input in_data, in_valid, vram_din, output in_ready, vram_addr, vram_dout, vram_we);
endinterface

// File: rtl/text_console.sv
// text_console: byte-stream writer for the text screen RAM; CONSOLE_SCROLL_EN enables upward scroll on last-row newline
module text_console #(
  parameter int         COLS  = 64,
  parameter int         ROWS  = 16,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                    clk,
  input  logic                    reset,
  text_console_if.slave           bus,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST    = AW'(ROWS * COLS - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [AW-1:0] COPY_LAST  = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] FILL_FIRST = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] FILL_LAST  = AW'(ROWS * COLS - 1);
  localparam logic [RW-1:0] WRAP_ROW   = ROW_MAX;
  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, FILL} state_t;
`else
  localparam logic [AW-1:0] FILL_FIRST = '0;
  localparam logic [AW-1:0] FILL_LAST  = AW'(COLS - 1);
  localparam logic [RW-1:0] WRAP_ROW   = '0;
  typedef enum logic [2:0] {CLEAR, IDLE, PUT, FILL} state_t;
`endif
  typedef enum logic [1:0] {ACT_NONE, ACT_WRAP, ACT_CLEAR} act_t;

  state_t        state;
  act_t          act;
  logic [7:0]    d;
  logic [RW-1:0] p_row, bs_row, nl_row, nx_row;
  logic [CW-1:0] p_col, bs_col, nx_col;
  logic [AW-1:0] idx, addr_r;
  logic [7:0]    dout_r;
  logic          we_r, ready_r;
  logic          printable, is_bs, go_home, do_nl, at_origin;
  act_t          nx_act;

  assign d = bus.in_data;
  assign bus.in_ready  = ready_r;
  assign bus.vram_addr = addr_r;
  assign bus.vram_we   = we_r;
`ifdef CONSOLE_SCROLL_EN
  assign bus.vram_dout = (state == SCROLL_WR) ? bus.vram_din : dout_r;
`else
  logic unused_din;
  assign unused_din    = ^bus.vram_din;
  assign bus.vram_dout = dout_r;
`endif

  // decode the offered byte into the write it needs and the cursor it leaves behind
  always_comb begin
    printable = d >= 8'h20;
    is_bs     = d == 8'h08;
    go_home   = d == 8'h1C || d == 8'h1F;
    do_nl     = d == 8'h0D || (printable && cursor_col == COL_MAX);
    at_origin = cursor_row == '0 && cursor_col == '0;
    bs_row    = (cursor_col != '0 || cursor_row == '0) ? cursor_row : cursor_row - 1'b1;
    bs_col    = at_origin ? '0 : cursor_col - 1'b1;
    nl_row    = (cursor_row == ROW_MAX) ? WRAP_ROW : cursor_row + 1'b1;
    nx_row    = do_nl ? nl_row : is_bs ? bs_row : go_home ? '0 : cursor_row;
    nx_col    = (do_nl || go_home) ? '0 : is_bs ? bs_col : printable ? cursor_col + 1'b1 : cursor_col;
    nx_act    = (d == 8'h1F) ? ACT_CLEAR : (do_nl && cursor_row == ROW_MAX) ? ACT_WRAP : ACT_NONE;
  end

  // control FSM; every RAM and handshake output is registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      act        <= ACT_NONE;
      cursor_row <= '0;
      cursor_col <= '0;
      p_row      <= '0;
      p_col      <= '0;
      idx        <= '0;
      addr_r     <= '0;
      dout_r     <= '0;
      we_r       <= 1'b0;
      ready_r    <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (!we_r) begin
            we_r   <= 1'b1;
            addr_r <= '0;
            dout_r <= BLANK;
            idx    <= '0;
          end else if (idx == LAST) begin
            state      <= IDLE;
            we_r       <= 1'b0;
            ready_r    <= 1'b1;
            busy       <= 1'b0;
            cursor_row <= '0;
            cursor_col <= '0;
          end else begin
            idx    <= idx + 1'b1;
            addr_r <= idx + 1'b1;
          end
        end
        IDLE: begin
          if (bus.in_valid) begin
            state   <= PUT;
            ready_r <= 1'b0;
            we_r    <= printable || is_bs;
            addr_r  <= is_bs ? {bs_row, bs_col} : {cursor_row, cursor_col};
            dout_r  <= is_bs ? BLANK : d;
            p_row   <= nx_row;
            p_col   <= nx_col;
            act     <= nx_act;
          end
        end
        PUT: begin
          we_r       <= 1'b0;
          cursor_row <= p_row;
          cursor_col <= p_col;
          if (act == ACT_CLEAR) begin
            state  <= CLEAR;
            we_r   <= 1'b1;
            addr_r <= '0;
            dout_r <= BLANK;
            idx    <= '0;
            busy   <= 1'b1;
          end else if (act == ACT_WRAP) begin
`ifdef CONSOLE_SCROLL_EN
            state  <= SCROLL_RD;
            addr_r <= AW'(COLS);
            idx    <= '0;
            busy   <= 1'b1;
`else
            state  <= FILL;
            we_r   <= 1'b1;
            addr_r <= FILL_FIRST;
            idx    <= FILL_FIRST;
            dout_r <= BLANK;
            busy   <= 1'b1;
`endif
          end else begin
            state   <= IDLE;
            ready_r <= 1'b1;
          end
        end
`ifdef CONSOLE_SCROLL_EN
        SCROLL_RD: begin
          state  <= SCROLL_WR;
          we_r   <= 1'b1;
          addr_r <= idx;
        end
        SCROLL_WR: begin
          if (idx == COPY_LAST) begin
            state  <= FILL;
            addr_r <= FILL_FIRST;
            idx    <= FILL_FIRST;
            dout_r <= BLANK;
          end else begin
            state  <= SCROLL_RD;
            we_r   <= 1'b0;
            idx    <= idx + 1'b1;
            addr_r <= idx + AW'(COLS + 1);
          end
        end
`endif
        FILL: begin
          if (idx == FILL_LAST) begin
            state   <= IDLE;
            we_r    <= 1'b0;
            ready_r <= 1'b1;
            busy    <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            addr_r <= idx + 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          we_r    <= 1'b0;
          ready_r <= 1'b0;
          busy    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_console.sv
// tb_text_console: directed and random byte streams against a screen/cursor reference model
module tb_text_console;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [7:0] ram [0:1023];
  logic [7:0] exp_ram [0:1023];
  logic [17:0] wlog [$];
  logic poke = 1'b0;
  logic [9:0] poke_a = '0;
  logic [7:0] poke_d = '0;
  int mr = 0;
  int mc = 0;
`ifdef CONSOLE_SCROLL_EN
  localparam int WRAP_BUSY = 1984;
  localparam int ABORT_AT  = 100;
`else
  localparam int WRAP_BUSY = 64;
  localparam int ABORT_AT  = 30;
`endif

  text_console_if #(.AW(10)) bus ();

  text_console dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // screen RAM: synchronous write, one-cycle registered read, write log
  always @(posedge clk) begin
    if (poke) ram[poke_a] <= poke_d;
    else if (bus.vram_we) begin
      ram[bus.vram_addr] <= bus.vram_dout;
      wlog.push_back({bus.vram_addr, bus.vram_dout});
    end
    bus.vram_din <= ram[bus.vram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_blank_all();
    for (int i = 0; i < 1024; i++) exp_ram[i] = 8'h20;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_nl();
    mc = 0;
    if (mr < 15) mr++;
    else begin
`ifdef CONSOLE_SCROLL_EN
      for (int i = 0; i < 960; i++) exp_ram[i] = exp_ram[i + 64];
      for (int i = 960; i < 1024; i++) exp_ram[i] = 8'h20;
      mr = 15;
`else
      for (int i = 0; i < 64; i++) exp_ram[i] = 8'h20;
      mr = 0;
`endif
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20) begin
      exp_ram[mr * 64 + mc] = b;
      if (mc == 63) model_nl();
      else mc++;
    end else if (b == 8'h0D) model_nl();
    else if (b == 8'h08) begin
      if (mc > 0) mc--;
      else if (mr > 0) begin
        mr--;
        mc = 63;
      end
      exp_ram[mr * 64 + mc] = 8'h20;
    end else if (b == 8'h1C) begin
      mr = 0;
      mc = 0;
    end else if (b == 8'h1F) model_blank_all();
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready("ready_before_send", 5000);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_chk(input logic [7:0] b);
    send(b);
    wait_ready("ready_after_send", 5000);
    chk("cursor_row", cursor_row, mr);
    chk("cursor_col", cursor_col, mc);
  endtask

  task automatic ram_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== exp_ram[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic clear_log_cmp(input string tag, input int mark);
    int bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mark + i >= wlog.size() || wlog[mark + i] !== {10'(i), 8'h20}) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic poke_cell(input int a, input logic [7:0] v);
    @(negedge clk);
    poke = 1'b1;
    poke_a = 10'(a);
    poke_d = v;
    exp_ram[a] = v;
  endtask

  initial begin
    int mark;
    int n;
    int bad;
    logic [7:0] b;
    logic [7:0] e;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_we", bus.vram_we, 0);
    chk("rst_busy", busy, 1);
    chk("rst_addr", bus.vram_addr, 0);
    chk("rst_dout", bus.vram_dout, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    mark = wlog.size();
    reset = 1'b1;
    model_blank_all();
    wait_ready("init_clear_done", 3000);
    chk("init_clear_writes", wlog.size() - mark, 1024);
    clear_log_cmp("init_clear_order", mark);
    ram_cmp("init_clear_ram");
    chk("init_cursor", {cursor_row, cursor_col}, 0);
    mark = wlog.size();
    send(8'h41);
    chk("put_we", bus.vram_we, 1);
    chk("put_addr", bus.vram_addr, 0);
    chk("put_data", bus.vram_dout, 8'h41);
    chk("put_ready_low", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("put_we_done", bus.vram_we, 0);
    chk("put_ready_back", bus.in_ready, 1);
    chk("put_cursor", {cursor_row, cursor_col}, {4'd0, 6'd1});
    chk("put_one_write", wlog.size() - mark, 1);
    send_chk(8'h1C);
    mark = wlog.size();
    for (int i = 0; i < 64; i++) send_chk(8'($urandom_range(32, 255)));
    bad = 0;
    for (int i = 0; i < 64; i++) if (wlog[mark + i][17:8] !== 10'(i)) bad++;
    chk("row_write_order", bad, 0);
    chk("row_cursor", {cursor_row, cursor_col}, {4'd1, 6'd0});
    send_chk(8'h08);
    chk("bs_write", wlog[wlog.size() - 1], {10'd63, 8'h20});
    chk("bs_cursor", {cursor_row, cursor_col}, {4'd0, 6'd63});
    ram_cmp("row_ram");
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 99);
      b = n < 70 ? 8'($urandom_range(32, 255)) : n < 82 ? 8'h0D : n < 90 ? 8'h08 : n < 93 ? 8'h1C : 8'($urandom_range(0, 31));
      send_chk(b);
    end
    ram_cmp("random_ram");
    send_chk(8'h1C);
    for (int i = 0; i < 15; i++) send_chk(8'h0D);
    for (int i = 0; i < 5; i++) send_chk(8'h61);
    for (int i = 0; i < 1024; i++) poke_cell(i, 8'(8'h40 + i / 64));
    @(negedge clk);
    poke = 1'b0;
    chk("wrap_setup_cursor", {cursor_row, cursor_col}, {4'd15, 6'd5});
    send(8'h0D);
    n = 0;
    for (int k = 0; k < 5000 && !bus.in_ready; k++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("wrap_busy_cycles", n, WRAP_BUSY);
    chk("wrap_done", bus.in_ready, 1);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
`ifdef CONSOLE_SCROLL_EN
      e = i < 960 ? 8'(8'h41 + i / 64) : 8'h20;
`else
      e = i < 64 ? 8'h20 : 8'(8'h40 + i / 64);
`endif
      if (ram[i] !== e) bad++;
    end
    chk("wrap_rows", bad, 0);
    ram_cmp("wrap_ram_model");
    chk("wrap_cursor_row", cursor_row, mr);
    chk("wrap_cursor_col", cursor_col, 0);
    wait_ready("hold_start", 100);
    mark = wlog.size();
    bus.in_data = 8'h1F;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    model_byte(8'h1F);
    bus.in_data = 8'h42;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("hold_second_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_byte(8'h42);
    wait_ready("hold_done", 100);
    chk("hold_writes", wlog.size() - mark, 1025);
    clear_log_cmp("hold_clear_order", mark);
    chk("hold_last_write", wlog[wlog.size() - 1], {10'd0, 8'h42});
    ram_cmp("hold_ram");
    chk("hold_cursor", {cursor_row, cursor_col}, {4'd0, 6'd1});
    send_chk(8'h1C);
    for (int i = 0; i < 15; i++) send_chk(8'h0D);
    send(8'h0D);
    repeat (ABORT_AT) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_we", bus.vram_we, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_cursor", {cursor_row, cursor_col}, 0);
    repeat (2) @(negedge clk);
    mark = wlog.size();
    reset = 1'b1;
    model_blank_all();
    wait_ready("abort_clear_done", 3000);
    chk("abort_clear_writes", wlog.size() - mark, 1024);
    clear_log_cmp("abort_clear_order", mark);
    ram_cmp("abort_ram");
    chk("abort_end_cursor", {cursor_row, cursor_col}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
